// File: rtl/vram_pkg.sv
// Shared constants, grant encoding and address-range helper for the VRAM arbiter.
package vram_pkg;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 8;
  localparam int VRAM_DEPTH = 16000;
  localparam int VID_LAT    = 3;

  // 640x400 scanout timing (pixels / lines)
  localparam int H   = 640;
  localparam int HFP = 16;
  localparam int HS  = 96;
  localparam int HBP = 48;
  localparam int V   = 400;
  localparam int VFP = 12;
  localparam int VS  = 2;
  localparam int VBP = 35;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_VID    = 2'd1,
    GNT_CPU_RD = 2'd2,
    GNT_CPU_WR = 2'd3
  } grant_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(VRAM_DEPTH);
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO buffering CPU writes as {addr,data} entries until a free VRAM slot.
module vram_wr_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic                     pclk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        pop_addr,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ADDR_W+DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [LVL_W-1:0]         count_r;
  logic                     do_push_s;
  logic                     do_pop_s;

  assign full      = (count_r == LVL_W'(DEPTH));
  assign empty     = (count_r == LVL_W'(0));
  assign level     = count_r;
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign {pop_addr, pop_data} = mem_r[rd_ptr_r];

  // Entry storage; contents need no reset since count_r gates visibility.
  always_ff @(posedge pclk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= {push_addr, push_data};
    end
  end

  // Pointers and occupancy; simultaneous push and pop keep the level.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + LVL_W'(1);
        2'b01:   count_r <= count_r - LVL_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches win every slot, CPU writes drain from a FIFO.
// Optional CPU read port is built when VRAM_ARB_CPU_READ_EN is defined.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          pclk,
  input  logic                          reset,
  input  logic                          vid_req,
  input  logic [ADDR_W-1:0]             vid_addr,
  output logic [DATA_W-1:0]             vid_rdata,
  output logic                          vid_rvalid,
  input  logic                          cpu_wr_valid,
  output logic                          cpu_wr_ready,
  input  logic [ADDR_W-1:0]             cpu_wr_addr,
  input  logic [DATA_W-1:0]             cpu_wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_oob,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata
`ifdef VRAM_ARB_CPU_READ_EN
  ,
  input  logic                          cpu_rd_valid,
  output logic                          cpu_rd_ready,
  input  logic [ADDR_W-1:0]             cpu_rd_addr,
  output logic [DATA_W-1:0]             cpu_rd_data,
  output logic                          cpu_rd_rvalid
`endif
);

  grant_t            grant_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              wr_hs_s;
  logic              push_s;
  logic              pop_s;
  logic [ADDR_W-1:0] fifo_addr_s;
  logic [DATA_W-1:0] fifo_data_s;
  logic              vid_s1_r;
  logic              vid_s2_r;

  assign cpu_wr_ready = !fifo_full_s;
  assign wr_hs_s      = cpu_wr_valid && cpu_wr_ready;
  assign push_s       = wr_hs_s && addr_in_range(cpu_wr_addr);
  assign pop_s        = (grant_s == GNT_CPU_WR);

`ifdef VRAM_ARB_CPU_READ_EN
  logic rd_s1_r;
  logic rd_s2_r;
  logic rd_oob1_r;
  logic rd_oob2_r;
  logic rd_hs_s;
  logic rd_in_range_s;

  // An empty FIFO at handshake time is what makes reads see all earlier writes.
  assign cpu_rd_ready  = fifo_empty_s && !vid_req && !rd_s1_r && !rd_s2_r;
  assign rd_hs_s       = cpu_rd_valid && cpu_rd_ready;
  assign rd_in_range_s = addr_in_range(cpu_rd_addr);
`endif

  vram_wr_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .pclk      (pclk),
    .reset     (reset),
    .push      (push_s),
    .push_addr (cpu_wr_addr),
    .push_data (cpu_wr_data),
    .pop       (pop_s),
    .pop_addr  (fifo_addr_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level)
  );

  // Fixed-priority slot grant for the current cycle.
  always_comb begin
    grant_s = GNT_NONE;
    if (vid_req) begin
      grant_s = GNT_VID;
    end
`ifdef VRAM_ARB_CPU_READ_EN
    else if (rd_hs_s && rd_in_range_s) begin
      grant_s = GNT_CPU_RD;
    end
`endif
    else if (!fifo_empty_s) begin
      grant_s = GNT_CPU_WR;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // RAM command register; address and write data hold when idle.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= {ADDR_W{1'b0}};
      ram_wdata <= {DATA_W{1'b0}};
    end else begin
      ram_en <= (grant_s != GNT_NONE);
      ram_we <= (grant_s == GNT_CPU_WR);
      case (grant_s)
        GNT_VID: ram_addr <= vid_addr;
`ifdef VRAM_ARB_CPU_READ_EN
        GNT_CPU_RD: ram_addr <= cpu_rd_addr;
`endif
        GNT_CPU_WR: begin
          ram_addr  <= fifo_addr_s;
          ram_wdata <= fifo_data_s;
        end
        default: begin
          ram_addr  <= ram_addr;
          ram_wdata <= ram_wdata;
        end
      endcase
    end
  end

  // Video return pipeline (grant, RAM read, RAM data, output) and OOB write flag.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vid_s1_r   <= 1'b0;
      vid_s2_r   <= 1'b0;
      vid_rvalid <= 1'b0;
      vid_rdata  <= {DATA_W{1'b0}};
      err_oob    <= 1'b0;
    end else begin
      vid_s1_r   <= (grant_s == GNT_VID);
      vid_s2_r   <= vid_s1_r;
      vid_rvalid <= vid_s2_r;
      if (vid_s2_r) begin
        vid_rdata <= ram_rdata;
      end
      err_oob <= wr_hs_s && !addr_in_range(cpu_wr_addr);
    end
  end

`ifdef VRAM_ARB_CPU_READ_EN
  // CPU read return pipeline; out-of-range reads skip the RAM and return zero.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      rd_s1_r       <= 1'b0;
      rd_s2_r       <= 1'b0;
      rd_oob1_r     <= 1'b0;
      rd_oob2_r     <= 1'b0;
      cpu_rd_rvalid <= 1'b0;
      cpu_rd_data   <= {DATA_W{1'b0}};
    end else begin
      rd_s1_r       <= rd_hs_s;
      rd_oob1_r     <= rd_hs_s && !rd_in_range_s;
      rd_s2_r       <= rd_s1_r;
      rd_oob2_r     <= rd_oob1_r;
      cpu_rd_rvalid <= rd_s2_r;
      if (rd_s2_r) begin
        cpu_rd_data <= rd_oob2_r ? {DATA_W{1'b0}} : ram_rdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a queue-based slot model predicts every RAM access and response.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int FD    = 4;
  localparam int LW    = $clog2(FD) + 1;
  localparam int K_VID = 0;
  localparam int K_WR  = 1;
  localparam int K_RD  = 2;
  localparam int K_CRD = 3;
  localparam int K_OOB = 4;

  logic              pclk = 1'b0;
  logic              reset = 1'b1;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_rvalid;
  logic              cpu_wr_valid = 1'b0;
  logic              cpu_wr_ready;
  logic [ADDR_W-1:0] cpu_wr_addr = '0;
  logic [DATA_W-1:0] cpu_wr_data = '0;
  logic [LW-1:0]     fifo_level;
  logic              err_oob;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
`ifdef VRAM_ARB_CPU_READ_EN
  logic              cpu_rd_valid = 1'b0;
  logic              cpu_rd_ready;
  logic [ADDR_W-1:0] cpu_rd_addr = '0;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              cpu_rd_rvalid;
`endif

  vram_arbiter #(.FIFO_DEPTH(FD)) dut (
    .pclk(pclk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .fifo_level(fifo_level), .err_oob(err_oob),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef VRAM_ARB_CPU_READ_EN
    , .cpu_rd_valid(cpu_rd_valid), .cpu_rd_ready(cpu_rd_ready), .cpu_rd_addr(cpu_rd_addr),
    .cpu_rd_data(cpu_rd_data), .cpu_rd_rvalid(cpu_rd_rvalid)
`endif
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Synchronous-read VRAM macro
  logic [DATA_W-1:0] ram_mem [0:16383];
  always @(posedge pclk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  typedef struct { int due; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } exp_t;
  typedef struct { int due; logic rdy; logic [LW-1:0] lvl; } st_t;

  exp_t              expq [5][$];
  st_t               exp_st[$];
  exp_t              mq[$];
  logic [DATA_W-1:0] model_mem [0:16383];
  int                total = 0;
  int                bad = 0;
  logic              rd_v = 1'b0;
  logic [ADDR_W-1:0] rd_a = '0;
  int                rd_busy = -10;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic chk_stream(input string nm, input logic fire, input logic [ADDR_W-1:0] ga,
                            input logic [DATA_W-1:0] gd, input bit use_a, input bit use_d, input int k);
    exp_t e;
    if (fire) begin
      total++;
      if (expq[k].size() == 0 || expq[k][0].due != cyc) begin
        bad++;
        $display("FAIL %s unexpected at cycle %0d addr=%0d data=%h", nm, cyc, ga, gd);
      end else begin
        e = expq[k].pop_front();
        if ((use_a && ga !== e.addr) || (use_d && gd !== e.data)) begin
          bad++;
          $display("FAIL %s cycle %0d got addr=%0d data=%h want addr=%0d data=%h",
                   nm, cyc, ga, gd, e.addr, e.data);
        end
      end
    end else if (expq[k].size() > 0 && expq[k][0].due == cyc) begin
      total++;
      bad++;
      e = expq[k].pop_front();
      $display("FAIL %s missing at cycle %0d want addr=%0d data=%h", nm, cyc, e.addr, e.data);
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations, mid-cycle
  always @(negedge pclk) begin
    st_t s;
    if (!reset) begin
      if (exp_st.size() > 0 && exp_st[0].due == cyc) begin
        s = exp_st.pop_front();
        check("cpu_wr_ready", 32'(cpu_wr_ready), 32'(s.rdy));
        check("fifo_level", 32'(fifo_level), 32'(s.lvl));
      end
      chk_stream("vid_rvalid", vid_rvalid, '0, vid_rdata, 1'b0, 1'b1, K_VID);
      chk_stream("ram_write", ram_en && ram_we, ram_addr, ram_wdata, 1'b1, 1'b1, K_WR);
      chk_stream("ram_read", ram_en && !ram_we, ram_addr, '0, 1'b1, 1'b0, K_RD);
      chk_stream("err_oob", err_oob, '0, '0, 1'b0, 1'b0, K_OOB);
`ifdef VRAM_ARB_CPU_READ_EN
      chk_stream("cpu_rd_rvalid", cpu_rd_rvalid, '0, cpu_rd_data, 1'b0, 1'b1, K_CRD);
`endif
    end
  end

  // One cycle of stimulus plus the reference slot decision for that cycle
  task automatic step(input logic v, input logic [ADDR_W-1:0] va, input logic wv,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd, output logic acc);
    exp_t e;
    st_t  s;
    logic rdy;
    logic rd_hs;
    @(posedge pclk); #1;
    vid_req = v; vid_addr = va;
    cpu_wr_valid = wv; cpu_wr_addr = wa; cpu_wr_data = wd;
    rd_hs = 1'b0;
`ifdef VRAM_ARB_CPU_READ_EN
    cpu_rd_valid = rd_v; cpu_rd_addr = rd_a;
    rd_hs = rd_v && !v && (mq.size() == 0) && (cyc > rd_busy);
`endif
    rdy = (mq.size() < FD);
    s = '{cyc, rdy, LW'(mq.size())};
    exp_st.push_back(s);
    acc = wv && rdy;
    if (v) begin
      e = '{cyc + 1, va, 8'h00};
      expq[K_RD].push_back(e);
      e = '{cyc + VID_LAT, va, model_mem[va]};
      expq[K_VID].push_back(e);
    end else if (rd_hs) begin
      rd_busy = cyc + 2;
      rd_v = 1'b0;
      e = '{cyc + 3, rd_a, 8'h00};
      if (int'(rd_a) < VRAM_DEPTH) begin
        e.data = model_mem[rd_a];
        expq[K_RD].push_back('{cyc + 1, rd_a, 8'h00});
      end
      expq[K_CRD].push_back(e);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      model_mem[e.addr] = e.data;
      e.due = cyc + 1;
      expq[K_WR].push_back(e);
    end
    if (acc) begin
      if (int'(wa) < VRAM_DEPTH) mq.push_back('{0, wa, wd});
      else expq[K_OOB].push_back('{cyc + 1, wa, wd});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ram_en"}, 32'(ram_en), 32'd0);
    check({tag, " ram_we"}, 32'(ram_we), 32'd0);
    check({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, " ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, " vid_rvalid"}, 32'(vid_rvalid), 32'd0);
    check({tag, " vid_rdata"}, 32'(vid_rdata), 32'd0);
    check({tag, " err_oob"}, 32'(err_oob), 32'd0);
    check({tag, " fifo_level"}, 32'(fifo_level), 32'd0);
    check({tag, " cpu_wr_ready"}, 32'(cpu_wr_ready), 32'd1);
  endtask

  initial begin
    logic acc;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    for (int i = 0; i < 16384; i++) begin
      ram_mem[i]   = 8'(i * 7 + 3);
      model_mem[i] = 8'(i * 7 + 3);
    end
    ram_mem[5]   = 8'h5A;
    model_mem[5] = 8'h5A;

    repeat (2) @(posedge pclk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Periodic scanout fetch of a preloaded pixel
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 14'd5, 1'b0, '0, '0, acc);
      repeat (3) step(1'b0, '0, 1'b0, '0, '0, acc);
    end

    // Fetch and write in the same cycle, then fetch the written pixel
    step(1'b1, 14'd9, 1'b1, 14'd10, 8'h33, acc);
    repeat (3) step(1'b0, '0, 1'b0, '0, '0, acc);
    step(1'b1, 14'd10, 1'b0, '0, '0, acc);
    repeat (4) step(1'b0, '0, 1'b0, '0, '0, acc);

    // Starve the CPU to fill the FIFO, then release and drain in order
    for (int i = 0; i < 5; i++) begin
      acc = 1'b0;
      for (int t = 0; t < 12 && !acc; t++)
        step(t < 6, 14'(20 + t), 1'b1, 14'(40 + i), 8'(8'hA0 + i), acc);
      check("fill_accept", 32'(acc), 32'd1);
    end
    repeat (8) step(1'b0, '0, 1'b0, '0, '0, acc);

    // Out-of-range write is accepted and flagged, never reaches the RAM
    step(1'b0, '0, 1'b1, 14'd16000, 8'hEE, acc);
    check("oob_accept", 32'(acc), 32'd1);
    repeat (3) step(1'b0, '0, 1'b0, '0, '0, acc);

`ifdef VRAM_ARB_CPU_READ_EN
    // Read right behind a write must wait for the FIFO to drain
    step(1'b0, '0, 1'b1, 14'd7, 8'h11, acc);
    rd_v = 1'b1; rd_a = 14'd7;
    for (int t = 0; t < 20 && rd_v; t++) step(1'b0, '0, 1'b0, '0, '0, acc);
    check("rd_handshake", 32'(rd_v), 32'd0);
    repeat (2) step(1'b0, '0, 1'b0, '0, '0, acc);
    rd_v = 1'b1; rd_a = 14'd16100;
    for (int t = 0; t < 20 && rd_v; t++) step(1'b0, '0, 1'b0, '0, '0, acc);
    check("rd_oob_handshake", 32'(rd_v), 32'd0);
    repeat (5) step(1'b0, '0, 1'b0, '0, '0, acc);
`endif

    // Randomized traffic: light then heavy video load
    for (int t = 0; t < 400; t++) begin
      wa = ($urandom_range(0, 15) == 0) ? 14'(16000 + $urandom_range(0, 383))
                                         : 14'($urandom_range(0, 31));
      wd = 8'($urandom);
      step((t < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           14'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), wa, wd, acc);
    end
    repeat (10) step(1'b0, '0, 1'b0, '0, '0, acc);

    // Reset with three writes queued and draining under way
    for (int i = 0; i < 3; i++) step(1'b1, 14'd20, 1'b1, 14'(100 + i), 8'(8'hC0 + i), acc);
    step(1'b0, '0, 1'b0, '0, '0, acc);
    @(posedge pclk); #1;
    reset = 1'b1;
    vid_req = 1'b0; cpu_wr_valid = 1'b0;
    mq.delete();
    exp_st.delete();
    for (int k = 0; k < 5; k++) expq[k].delete();
    #2;
    check_reset_outputs("mid_reset");
    @(posedge pclk); #1;
    reset = 1'b0;
    repeat (10) step(1'b0, '0, 1'b0, '0, '0, acc);

    @(negedge pclk); #1;
    for (int k = 0; k < 5; k++) check("leftover_expect", 32'(expq[k].size()), 32'd0);
    check("leftover_status", 32'(exp_st.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
